// File: rtl/io_input_sequencer.sv
// Stalls the CPU on a switch read until confirm_button is debounced-pressed and released.
// Optional WAIT_PRESS timeout enabled by defining IO_TIMEOUT_EN.
module io_input_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 100000,
   parameter int unsigned CNT_WIDTH       = 17,
   parameter int unsigned TIMEOUT_CYCLES  = 2**24
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        io_read_req,
   input  logic        switch_sel,
   input  logic        confirm_button,
   input  logic [15:0] switches,
   output logic        cpu_stall,
   output logic [15:0] io_rdata,
   output logic        rdata_valid,
   output logic        busy,
   output logic        timeout_flag
);

   typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, DONE} state_t;

   if (DEBOUNCE_CYCLES < 1 || 64'(DEBOUNCE_CYCLES - 1) >= (64'd1 << CNT_WIDTH)) begin : g_bad_cnt
      $error("CNT_WIDTH too small for DEBOUNCE_CYCLES");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   state_t                 state;
   logic                   btn_s1, btn_s2;
   logic [15:0]            sw_s1, sw_s2;
   logic [CNT_WIDTH-1:0]   deb_cnt;
   logic                   deb_btn, deb_btn_d;
   logic                   press, release_evt, req;

   assign req         = io_read_req & switch_sel;
   assign press       = deb_btn & ~deb_btn_d;
   assign release_evt = ~deb_btn & deb_btn_d;
   assign busy        = (state != IDLE);
   // Combinational so the PC is held on the request cycle itself; forced low during reset.
   assign cpu_stall   = ~reset & (((state == IDLE) & req) | (state == WAIT_PRESS) |
                                  (state == WAIT_RELEASE));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         btn_s1    <= 1'b0;
         btn_s2    <= 1'b0;
         sw_s1     <= '0;
         sw_s2     <= '0;
         deb_cnt   <= '0;
         deb_btn   <= 1'b0;
         deb_btn_d <= 1'b0;
      end else begin
         btn_s1    <= confirm_button;
         btn_s2    <= btn_s1;
         sw_s1     <= switches;
         sw_s2     <= sw_s1;
         deb_btn_d <= deb_btn;
         if (btn_s2 != deb_btn) begin
            if (deb_cnt == CNT_WIDTH'(DEBOUNCE_CYCLES - 1)) begin
               deb_btn <= ~deb_btn;
               deb_cnt <= '0;
            end else begin
               deb_cnt <= deb_cnt + 1'b1;
            end
         end else begin
            deb_cnt <= '0;
         end
      end
   end

`ifdef IO_TIMEOUT_EN
   localparam int unsigned TO_WIDTH = $clog2(TIMEOUT_CYCLES);
   logic [TO_WIDTH-1:0] to_cnt;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         io_rdata     <= '0;
         rdata_valid  <= 1'b0;
`ifdef IO_TIMEOUT_EN
         to_cnt       <= '0;
         timeout_flag <= 1'b0;
`endif
      end else begin
         rdata_valid <= 1'b0;
         unique case (state)
            IDLE: begin
`ifdef IO_TIMEOUT_EN
               to_cnt <= '0;
`endif
               if (req) state <= WAIT_PRESS;
            end
            WAIT_PRESS: begin
`ifdef IO_TIMEOUT_EN
               to_cnt <= to_cnt + 1'b1;
`endif
               if (!req) begin
                  state <= IDLE;
               end else if (press) begin
                  io_rdata <= sw_s2;
                  state    <= WAIT_RELEASE;
`ifdef IO_TIMEOUT_EN
               end else if (to_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                  io_rdata     <= sw_s2;
                  rdata_valid  <= 1'b1;
                  timeout_flag <= 1'b1;
                  state        <= DONE;
`endif
               end
            end
            WAIT_RELEASE: begin
               if (!req) begin
                  state <= IDLE;
               end else if (release_evt) begin
                  rdata_valid <= 1'b1;
`ifdef IO_TIMEOUT_EN
                  timeout_flag <= 1'b0;
`endif
                  state <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifndef IO_TIMEOUT_EN
   assign timeout_flag = 1'b0;
`endif

endmodule
